// File: rtl/cla_pkg.sv
// cla_pkg: shared types and helpers for the pipelined CLA adder/subtractor.
//   op_t : operation select carried on the operand handshake
//   ng() : number of pipeline stages (one lookahead group per stage)
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int ng(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if: operand and result handshakes of cla_pipe_addsub.
//   in_valid/in_ready  : operand transfer (in_a, in_b, in_op)
//   out_valid/out_ready: result transfer (out_sum, out_cout, out_ovf)
//   master modport = producer of operands / consumer of results
//   slave modport  = the adder itself
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  import cla_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  op_t              in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/cla_group.sv
// cla_group: purely combinational GROUP-bit carry-lookahead slice.
//   a, b : operand bits of this group (b already inverted for subtraction)
//   cin  : carry into bit 0 of the group
//   s    : sum bits
//   cout : carry out of the group
//   pg   : group propagate (all bits propagate)
//   gg   : group generate (carry produced inside the group, independent of cin)
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products of g/p terms, not a ripple chain.
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    for (int i = 0; i <= GROUP; i++) begin
      term = cin;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign pg   = &p;
  // p and g are exclusive per bit, so when every bit propagates nothing is
  // generated; otherwise the cin term of c[GROUP] is zero and it equals gg.
  assign gg   = c[GROUP] & ~pg;

endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of cla_pipe_addsub_if (operands in, results out)
//   WIDTH      : operand width, multiple of GROUP
//   GROUP      : bits resolved per stage; NG = WIDTH/GROUP stages
// Stage k resolves bits [GROUP*(k+1)-1 : GROUP*k] and registers its carry.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic            clk,
  input logic            rst_n,
  cla_pipe_addsub_if.slave bus
);

  localparam int NG = ng(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0) begin : g_bad_cfg
    $fatal(1, "cla_pipe_addsub: WIDTH must be a multiple of GROUP");
  end

  logic [NG-1:0]    v;
  logic [NG-1:0]    c_q;
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] s_q [NG];

  logic [WIDTH-1:0] a_in [NG];
  logic [WIDTH-1:0] b_in [NG];
  logic [WIDTH-1:0] s_in [NG];
  logic [WIDTH-1:0] s_nx [NG];
  logic [NG-1:0]    c_in;
  logic [NG-1:0]    v_in;
  logic [NG-1:0]    ld;
  logic [NG-1:0]    grp_c;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [GROUP-1:0] grp_s [NG];
  logic             sign_top;

  // Stage inputs: stage 0 takes the bus (B inverted, carry-in 1 for SUB),
  // later stages take the registered fields of the stage before.
  always_comb begin
    a_in[0] = bus.in_a;
    b_in[0] = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
    s_in[0] = '0;
    c_in    = '0;
    c_in[0] = (bus.in_op == OP_SUB);
    v_in    = '0;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < NG; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v[k-1];
    end
    for (int k = 0; k < NG; k++) begin
      s_nx[k] = s_in[k];
      s_nx[k][k*GROUP +: GROUP] = grp_s[k];
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_stage
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (a_in[k][k*GROUP +: GROUP]),
      .b   (b_in[k][k*GROUP +: GROUP]),
      .cin (c_in[k]),
      .s   (grp_s[k]),
      .cout(grp_c[k]),
      .pg  (grp_p[k]),
      .gg  (grp_g[k])
    );
  end

  // Stage k loads when empty or when it drains forward; walking from the
  // output end, "drains" reduces to "the next stage loads" (or out_ready).
  always_comb begin
    logic nxt;
    ld  = '0;
    nxt = bus.out_ready;
    for (int k = NG - 1; k >= 0; k--) begin
      ld[k] = !v[k] || nxt;
      nxt   = ld[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      c_q <= '0;
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NG; k++) begin
        if (ld[k]) begin
          v[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_nx[k];
            c_q[k] <= grp_c[k];
          end
        end
      end
    end
  end

  // Sign extension: A and B' sign bits plus the carry into bit WIDTH.
  assign sign_top      = a_q[NG-1][WIDTH-1] ^ b_q[NG-1][WIDTH-1] ^ c_q[NG-1];
  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v[NG-1];
  assign bus.out_sum   = {sign_top, s_q[NG-1]};
  assign bus.out_cout  = c_q[NG-1];
  assign bus.out_ovf   = sign_top ^ s_q[NG-1][WIDTH-1];

  // Group P/G are kept for a two-level lookahead variant.
  logic unused_grp_pg;
  assign unused_grp_pg = ^{grp_p, grp_g};

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: scoreboard bench for cla_pipe_addsub.
// dut0: WIDTH=16, GROUP=4 (NG=4); dut1: WIDTH=16, GROUP=16 (NG=1).
module tb_cla_pipe_addsub;
  import cla_pkg::*;

  localparam int W   = 16;
  localparam int NG0 = 4;
  localparam int NG1 = 1;

  logic clk;
  logic rst_n;

  cla_pipe_addsub_if #(.WIDTH(W)) ifc0 ();
  cla_pipe_addsub_if #(.WIDTH(W)) ifc1 ();

  cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc0)
  );

  cla_pipe_addsub #(.WIDTH(W), .GROUP(16)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc1)
  );

  typedef struct {
    logic [W:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stall0 = 0;
  logic [W:0] hold_sum;
  logic hold_cout;
  logic hold_ovf;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, bit sub, int lat);
    exp_t e;
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb);
    e.sum  = r[W:0];
    e.cout = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
    e.ovf  = (r > 32767) || (r < -32768);
    e.acc  = cyc;
    e.lat  = lat;
    return e;
  endfunction

  function automatic void check_out(exp_t e, logic [W:0] s, logic c, logic o, string tag);
    chk({tag, "_sum"},  32'(s), 32'(e.sum));
    chk({tag, "_cout"}, 32'(c), 32'(e.cout));
    chk({tag, "_ovf"},  32'(o), 32'(e.ovf));
    if (e.lat >= 0) chk({tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
  endfunction

  // Monitors: pop and compare whenever a result transfer happens.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall0) begin
        chk("hold_valid0", 32'(ifc0.out_valid), 32'd1);
        chk("hold_sum0",   32'(ifc0.out_sum),   32'(hold_sum));
        chk("hold_cout0",  32'(ifc0.out_cout),  32'(hold_cout));
        chk("hold_ovf0",   32'(ifc0.out_ovf),   32'(hold_ovf));
      end
      if (ifc0.out_valid && ifc0.out_ready) begin
        if (q0.size() == 0) chk("unexpected_out0", 32'd1, 32'd0);
        else check_out(q0.pop_front(), ifc0.out_sum, ifc0.out_cout, ifc0.out_ovf, "dut0");
      end
      stall0    = ifc0.out_valid && !ifc0.out_ready;
      hold_sum  = ifc0.out_sum;
      hold_cout = ifc0.out_cout;
      hold_ovf  = ifc0.out_ovf;
    end else begin
      stall0 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifc1.out_valid && ifc1.out_ready) begin
      if (q1.size() == 0) chk("unexpected_out1", 32'd1, 32'd0);
      else check_out(q1.pop_front(), ifc1.out_sum, ifc1.out_cout, ifc1.out_ovf, "dut1");
    end
  end

  task automatic drive(int sel, logic [W-1:0] a, logic [W-1:0] b, bit sub);
    if (sel == 0) begin
      ifc0.in_valid = 1'b1; ifc0.in_a = a; ifc0.in_b = b;
      ifc0.in_op = sub ? OP_SUB : OP_ADD;
    end else begin
      ifc1.in_valid = 1'b1; ifc1.in_a = a; ifc1.in_b = b;
      ifc1.in_op = sub ? OP_SUB : OP_ADD;
    end
  endtask

  task automatic idle(int sel);
    if (sel == 0) ifc0.in_valid = 1'b0;
    else ifc1.in_valid = 1'b0;
  endtask

  // Offer one transaction until accepted (bounded); expected result is
  // queued at the cycle of acceptance.
  task automatic send(int sel, logic [W-1:0] a, logic [W-1:0] b, bit sub, int lat);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    drive(sel, a, b, sub);
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = (sel == 0) ? ifc0.in_ready : ifc1.in_ready;
      if (acc) begin
        if (sel == 0) q0.push_back(model(a, b, sub, lat));
        else q1.push_back(model(a, b, sub, lat));
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk((sel == 0) ? "drain0" : "drain1", 32'((sel == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  // Hold out_ready low for ncyc cycles while offering fresh operands.
  task automatic backpressure(int sel, int ncyc, int exp_acc);
    logic [W-1:0] ra, rb;
    bit rs, acc;
    int nacc;
    nacc = 0;
    if (sel == 0) ifc0.out_ready = 1'b0; else ifc1.out_ready = 1'b0;
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
    drive(sel, ra, rb, rs);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      acc = (sel == 0) ? ifc0.in_ready : ifc1.in_ready;
      if (acc) begin
        if (sel == 0) q0.push_back(model(ra, rb, rs, -1));
        else q1.push_back(model(ra, rb, rs, -1));
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
        drive(sel, ra, rb, rs);
      end
    end
    chk("bp_accepts", 32'(nacc), 32'(exp_acc));
    @(negedge clk);
    chk("bp_in_ready_low", 32'((sel == 0) ? ifc0.in_ready : ifc1.in_ready), 32'd0);
    @(posedge clk); #1;
    idle(sel);
    if (sel == 0) ifc0.out_ready = 1'b1; else ifc1.out_ready = 1'b1;
    drain(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n = 1'b1;
    ifc0.in_valid = 0; ifc0.in_a = '0; ifc0.in_b = '0; ifc0.in_op = OP_ADD; ifc0.out_ready = 1;
    ifc1.in_valid = 0; ifc1.in_a = '0; ifc1.in_b = '0; ifc1.in_op = OP_ADD; ifc1.out_ready = 1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifc0.out_valid), 32'd0);
    chk("rst_out_sum",   32'(ifc0.out_sum),   32'd0);
    chk("rst_out_cout",  32'(ifc0.out_cout),  32'd0);
    chk("rst_out_ovf",   32'(ifc0.out_ovf),   32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready0", 32'(ifc0.in_ready), 32'd1);
    chk("rel_in_ready1", 32'(ifc1.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed corner cases.
    send(0, 16'h7FFF, 16'h0001, 1'b0, NG0);
    send(0, 16'h0000, 16'h0001, 1'b1, NG0);
    send(0, 16'h8000, 16'h0001, 1'b1, NG0);
    send(0, 16'hFFFF, 16'h0001, 1'b0, NG0);
    send(0, 16'h8000, 16'h8000, 1'b0, NG0);
    idle(0);
    drain(0);

    // Back-to-back streaming: fixed latency implies consecutive results.
    for (int i = 0; i < 8; i++)
      send(0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), NG0);
    idle(0);
    drain(0);

    // Random out_ready throttling.
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1);
        idle(0);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ifc0.out_ready = ($urandom_range(0, 3) != 0);
        end
        ifc0.out_ready = 1'b1;
      end
    join
    drain(0);

    backpressure(0, 6, NG0);

    // Reset with three transactions in flight.
    ifc0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1);
    idle(0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ifc0.out_valid), 32'd0);
    chk("midrst_out_sum",   32'(ifc0.out_sum),   32'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc0.out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(ifc0.in_ready), 32'd1);
    nv = 0;
    for (int i = 0; i < NG0 + 4; i++) begin
      @(negedge clk);
      if (ifc0.out_valid) nv++;
    end
    chk("midrst_no_valid", 32'(nv), 32'd0);
    @(posedge clk); #1;

    // Single-stage configuration.
    send(1, 16'h7FFF, 16'h0001, 1'b0, NG1);
    send(1, 16'h8000, 16'h0001, 1'b1, NG1);
    for (int i = 0; i < 6; i++)
      send(1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), NG1);
    idle(1);
    drain(1);
    backpressure(1, 4, NG1);

    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
